// File: rtl/timer_cmd_pkg.sv
// Shared definitions for the serial timer-command link (transmitter and receiver).
`timescale 1ns/1ps
package timer_cmd_pkg;

    localparam int         DELAY_W_DEFAULT  = 4;
    localparam logic [3:0] PREAMBLE_DEFAULT = 4'b1101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_PAYLOAD,
        ST_WAIT_DONE,
        ST_ACK,
        ST_ERR
    } tx_state_e;

endpackage

// File: rtl/timer_cmd_piso.sv
// Parallel-load, MSB-first shift register carrying the delay payload onto the wire.
`timescale 1ns/1ps
module timer_cmd_piso #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-1:0] din_i,
    output logic         msb_o
);

    logic [W-1:0] sh_q, sh_d;

    // Load has priority; the FSM never asserts both in the same cycle anyway.
    always_comb begin
        sh_d = sh_q;
        if (load_i)
            sh_d = din_i;
        else if (shift_i)
            sh_d = sh_q << 1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            sh_q <= '0;
        else
            sh_q <= sh_d;
    end

    assign msb_o = sh_q[W-1];

endmodule

// File: rtl/timer_cmd_tx.sv
// Transmit side of the timer-command link: preamble + MSB-first delay, then a
// wait for the remote done with optional timeout, answered by a one-cycle ack.
`timescale 1ns/1ps
module timer_cmd_tx
    import timer_cmd_pkg::*;
#(
    parameter int         DELAY_W        = DELAY_W_DEFAULT,
    parameter logic [3:0] PREAMBLE       = PREAMBLE_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 20000,
    parameter int         TMO_W          = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [DELAY_W-1:0] req_delay,
    output logic               data,
    input  logic               done,
    output logic               ack,
    output logic               busy,
    output logic               timeout_err
);

    // One counter indexes both the preamble (4 bits) and the payload.
    localparam int               CNT_W    = (DELAY_W > 4) ? $clog2(DELAY_W) : 2;
    localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(DELAY_W - 1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(3);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    tx_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [TMO_W-1:0] tmo_q;
    logic             sh_msb;
    logic             sh_load, sh_shift;

    assign sh_load  = (state_q == ST_IDLE) && req_valid;
    assign sh_shift = (state_q == ST_PAYLOAD);

    timer_cmd_piso #(.W(DELAY_W)) u_piso (
        .clk     (clk),
        .reset   (reset),
        .load_i  (sh_load),
        .shift_i (sh_shift),
        .din_i   (req_delay),
        .msb_o   (sh_msb)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tmo_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (req_valid)
                        state_q <= ST_PRE;
                end
                ST_PRE: begin
                    if (cnt_q == PRE_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_PAYLOAD;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_PAYLOAD: begin
                    if (cnt_q == PAY_LAST) begin
                        cnt_q   <= '0;
                        tmo_q   <= '0;
                        state_q <= ST_WAIT_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    // done on the timeout cycle still counts as a completion.
                    if (done)
                        state_q <= ST_ACK;
                    else if ((TIMEOUT_CYCLES != 0) && (tmo_q == TMO_LAST))
                        state_q <= ST_ERR;
                    else
                        tmo_q <= tmo_q + 1'b1;
                end
                ST_ACK:  state_q <= ST_IDLE;
                ST_ERR:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        data = 1'b0;
        case (state_q)
            ST_PRE:     data = PREAMBLE[2'd3 - cnt_q[1:0]];
            ST_PAYLOAD: data = sh_msb;
            default:    data = 1'b0;
        endcase
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign ack         = (state_q == ST_ACK);
    assign timeout_err = (state_q == ST_ERR);

endmodule

// File: tb/tb_timer_cmd_tx.sv
// Directed + randomized bench for timer_cmd_tx with a wire-level receiver model.
`timescale 1ns/1ps
module tb_timer_cmd_tx;

    localparam int DW  = 4;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [DW-1:0] req_delay;
    logic          data;
    logic          done;
    logic          ack;
    logic          busy;
    logic          timeout_err;

    int checks   = 0;
    int failures = 0;
    int rx_q[$];
    int exp_q[$];
    int ack_cnt  = 0;
    int exp_acks = 0;

    always #5 clk = ~clk;

    timer_cmd_tx #(
        .DELAY_W        (DW),
        .PREAMBLE       (4'b1101),
        .TIMEOUT_CYCLES (TMO),
        .TMO_W          (15)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_delay   (req_delay),
        .data        (data),
        .done        (done),
        .ack         (ack),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    // Receiver model: hunt for 1101, then take DW bits MSB first.
    logic [3:0] rx_win;
    logic [3:0] rx_val;
    int         rx_cnt;
    bit         rx_coll;
    always @(negedge clk) begin
        if (reset) begin
            rx_win  = '0;
            rx_val  = '0;
            rx_cnt  = 0;
            rx_coll = 1'b0;
        end else if (rx_coll) begin
            rx_val = {rx_val[2:0], data};
            rx_cnt++;
            if (rx_cnt == DW) begin
                rx_q.push_back(int'(rx_val));
                rx_coll = 1'b0;
            end
        end else begin
            rx_win = {rx_win[2:0], data};
            if (rx_win == 4'b1101) begin
                rx_coll = 1'b1;
                rx_cnt  = 0;
                rx_win  = '0;
            end
        end
        if (!reset && ack) ack_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full frame. done_at = WAIT_DONE cycle (1-based) carrying done; >TMO means never.
    // noise toggles done randomly while it must be ignored; req_valid stays high throughout.
    task automatic send_frame(input logic [3:0] d, input int done_at, input bit noise);
        logic [7:0] bits;
        bits = {4'b1101, d};
        chk("idle_ready", req_ready, 1);
        chk("idle_busy", busy, 0);
        chk("idle_data", data, 0);
        req_valid = 1'b1;
        req_delay = d;
        done      = noise ? 1'($urandom) : 1'b0;
        step();
        req_delay = 4'($urandom);
        done      = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("wire_bit%0d d=%0d", i, d), data, bits[7-i]);
            chk("wire_busy", busy, 1);
            chk("wire_ready", req_ready, 0);
            chk("wire_ack", ack, 0);
            if (noise) done = 1'($urandom);
            step();
        end
        done = 1'b0;
        for (int k = 1; k <= TMO; k++) begin
            chk($sformatf("wait_data k=%0d", k), data, 0);
            chk("wait_ack", ack, 0);
            chk("wait_terr", timeout_err, 0);
            chk("wait_busy", busy, 1);
            done = (k == done_at);
            step();
            done = 1'b0;
            if (k == done_at) break;
        end
        exp_q.push_back(int'(d));
        if (done_at <= TMO) begin
            chk("ack_pulse", ack, 1);
            chk("ack_terr", timeout_err, 0);
            chk("ack_data", data, 0);
            exp_acks++;
        end else begin
            chk("terr_pulse", timeout_err, 1);
            chk("terr_ack", ack, 0);
        end
        step();
        chk("post_ready", req_ready, 1);
        chk("post_busy", busy, 0);
        chk("post_ack", ack, 0);
        chk("post_terr", timeout_err, 0);
    endtask

    initial begin
        logic [3:0] d;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_delay = '0;
        done      = 1'b0;
        step();
        chk("rst_data", data, 0);
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_terr", timeout_err, 0);
        chk("rst_ready", req_ready, 1);
        step();
        reset = 1'b0;

        // Reference frame 1010, done on the 5th wait cycle.
        send_frame(4'b1010, 5, 1'b0);
        req_valid = 1'b0;

        // done in IDLE is ignored.
        done = 1'b1;
        step();
        done = 1'b0;
        chk("idle_done_busy", busy, 0);
        chk("idle_done_ack", ack, 0);
        send_frame(4'($urandom), 3, 1'b1);

        // Back-to-back extreme payloads with req_valid held.
        send_frame(4'd0, int'($urandom_range(1, 16)), 1'b0);
        send_frame(4'd15, int'($urandom_range(1, 16)), 1'b0);
        req_valid = 1'b0;

        // Timeout, then done exactly on the last allowed cycle.
        send_frame(4'($urandom), TMO + 1, 1'b0);
        send_frame(4'($urandom), TMO, 1'b0);
        req_valid = 1'b0;

        // Reset in the 2nd payload cycle aborts the frame.
        d         = 4'($urandom);
        req_valid = 1'b1;
        req_delay = d;
        step();
        req_valid = 1'b0;
        repeat (5) step();
        chk("abort_bit1", data, d[2]);
        reset = 1'b1;
        step();
        chk("abort_data", data, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ack", ack, 0);
        reset = 1'b0;
        send_frame(4'($urandom), int'($urandom_range(1, 8)), 1'b0);
        req_valid = 1'b0;

        for (int n = 0; n < 8; n++)
            send_frame(4'($urandom), int'($urandom_range(1, 20)), 1'($urandom));
        req_valid = 1'b0;
        repeat (3) step();

        chk("rx_count", rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            chk($sformatf("rx_val%0d", i), rx_q[i], exp_q[i]);
        chk("ack_count", ack_cnt, exp_acks);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
